// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared types and defaults for the adder scheduler.
// Holds the FSM state enum, default W/N/LAT and a pointer-wrap helper.

package adder_sched_pkg;

    // Default configuration
    localparam int DEF_W   = 16;
    localparam int DEF_N   = 4;
    localparam int DEF_LAT = 2;

    // Scheduler FSM states; one operation in flight at a time
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Increment v, wrapping from n-1 back to 0
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/adder_sched_rr_arb.sv
// adder_sched_rr_arb: picks one winner among N requesters.
// Ports: req (N), p (start pointer) -> grant (one-hot N), index (winner).
// Macro ADDER_SCHED_FIXED_PRIO_EN: lowest index wins and p is ignored;
// otherwise the search starts at p and wraps (round-robin).

import adder_sched_pkg::*;

module adder_sched_rr_arb #(
    parameter  int N  = DEF_N,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] p,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);

    logic found;

`ifdef ADDER_SCHED_FIXED_PRIO_EN

    logic unused_p;
    assign unused_p = ^p;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                index    = IW'(k);
            end
        end
    end

`else

    int j;

    // Scan N positions starting at p; first set bit wins
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(p) + k) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                index    = IW'(j);
            end
        end
    end

`endif

endmodule

// File: rtl/adder_sched.sv
// adder_sched: shares one LAT-cycle adder among N requesters.
// Ports: clk, rst (async, active-high); req/a_in/b_in in, gnt out per
// requester; rsp_valid/rsp_y response; busy; dp_start/dp_a/dp_b/dp_y
// to the shared adder. Macro ADDER_SCHED_FIXED_PRIO_EN selects fixed
// priority arbitration instead of round-robin.

import adder_sched_pkg::*;

module adder_sched #(
    parameter int W   = DEF_W,
    parameter int N   = DEF_N,
    parameter int LAT = DEF_LAT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] a_in,
    input  logic [N*W-1:0] b_in,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_y,
    output logic           busy,
    output logic           dp_start,
    output logic [W-1:0]   dp_a,
    output logic [W-1:0]   dp_b,
    input  logic [W-1:0]   dp_y
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(LAT + 1);

    state_e         state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  win_q, win_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [N-1:0]   rsp_valid_q, rsp_valid_d;
    logic [W-1:0]   rsp_y_q, rsp_y_d;
    logic [W-1:0]   dp_a_q, dp_a_d;
    logic [W-1:0]   dp_b_q, dp_b_d;
    logic           dp_start_q, dp_start_d;
    logic           busy_q, busy_d;

    logic [N-1:0]   arb_gnt;
    logic [IW-1:0]  arb_idx;
    logic [W-1:0]   sel_a, sel_b;

    adder_sched_rr_arb #(
        .N (N)
    ) u_arb (
        .req   (req),
        .p     (ptr_q),
        .grant (arb_gnt),
        .index (arb_idx)
    );

    // Operand mux driven by the one-hot grant
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (arb_gnt[i]) begin
                sel_a = a_in[i*W +: W];
                sel_b = b_in[i*W +: W];
            end
        end
    end

    // All outputs are registered, so each lags the decision by a cycle:
    // gnt and busy rise with ISSUE, dp_start is visible in the first WAIT
    // cycle, and rsp_valid/rsp_y appear in the IDLE cycle after RESP.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_y_d     = rsp_y_q;
        dp_a_d      = dp_a_q;
        dp_b_d      = dp_b_q;
        dp_start_d  = 1'b0;
        busy_d      = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = arb_gnt;
                    win_d   = arb_idx;
                    dp_a_d  = sel_a;
                    dp_b_d  = sel_b;
                    ptr_d   = IW'(wrap_inc(int'(arb_idx), N));
                    busy_d  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                dp_start_d = 1'b1;
                cnt_d      = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // First WAIT cycle carries dp_start; LAT-1 more follow,
                // so RESP samples dp_y exactly LAT cycles after it.
                if (cnt_q == CW'(LAT - 1)) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                rsp_y_d = dp_y;
                for (int i = 0; i < N; i++) begin
                    rsp_valid_d[i] = (win_q == IW'(i));
                end
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_y_q     <= '0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            dp_start_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            dp_a_q      <= dp_a_d;
            dp_b_q      <= dp_b_d;
            dp_start_q  <= dp_start_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign busy      = busy_q;
    assign dp_start  = dp_start_q;
    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;

endmodule

// File: tb/tb_adder_sched.sv
// tb_adder_sched: directed + random stimulus against a reference model.
// The shared adder is modelled as a LAT-deep pipe fed with junk when idle.

module tb_adder_sched;

    localparam int W   = 16;
    localparam int N   = 4;
    localparam int LAT = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_y;
    logic           busy;
    logic           dp_start;
    logic [W-1:0]   dp_a;
    logic [W-1:0]   dp_b;
    logic [W-1:0]   dp_y;

    int nerr  = 0;
    int nchk  = 0;
    int ptr_m = 0;

    always #5 clk = ~clk;

    adder_sched #(
        .W   (W),
        .N   (N),
        .LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_y     (rsp_y),
        .busy      (busy),
        .dp_start  (dp_start),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_y      (dp_y)
    );

    // Adder: result valid LAT cycles after the dp_start cycle;
    // all other slots carry random junk to expose mistimed sampling.
    logic [W-1:0] pipe [LAT];

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= dp_start ? W'(dp_a + dp_b) : W'($urandom);
    end

    assign dp_y = pipe[LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration from the request vector and model pointer
    function automatic int pick(input logic [N-1:0] r);
`ifdef ADDER_SCHED_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (r[k]) return k;
`else
        for (int k = 0; k < N; k++) begin
            if (r[(ptr_m + k) % N]) return (ptr_m + k) % N;
        end
`endif
        return 0;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            a_in[i*W +: W] = W'($urandom);
            b_in[i*W +: W] = W'($urandom);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"},   64'(gnt),       64'(0));
        chk({tag, "_rspv"},  64'(rsp_valid), 64'(0));
        chk({tag, "_rspy"},  64'(rsp_y),     64'(0));
        chk({tag, "_start"}, 64'(dp_start),  64'(0));
        chk({tag, "_dpa"},   64'(dp_a),      64'(0));
        chk({tag, "_dpb"},   64'(dp_b),      64'(0));
        chk({tag, "_busy"},  64'(busy),      64'(0));
    endtask

    // One operation from an IDLE cycle to its response cycle.
    task automatic do_op(input logic [N-1:0] r, input bit hold,
                         input bit noise);
        int           w;
        logic [W-1:0] ea, eb, ey;
        logic [N-1:0] oh;
        w  = pick(r);
        ea = a_in[w*W +: W];
        eb = b_in[w*W +: W];
        ey = ea + eb;
        oh = '0;
        oh[w] = 1'b1;
        req = r;
        step();
        chk("gnt", 64'(gnt), 64'(oh));
        chk("busy_on", 64'(busy), 64'(1));
`ifndef ADDER_SCHED_FIXED_PRIO_EN
        ptr_m = (w + 1) % N;
`endif
        if (!hold) req[w] = 1'b0;
        if (noise) begin
            req = N'($urandom);
            rand_ops();
        end
        step();
        chk("start", 64'(dp_start), 64'(1));
        chk("dp_a", 64'(dp_a), 64'(ea));
        chk("dp_b", 64'(dp_b), 64'(eb));
        chk("gnt_pulse", 64'(gnt), 64'(0));
        for (int c = 0; c < LAT; c++) begin
            step();
            chk("start_off", 64'(dp_start), 64'(0));
            chk("rspv_early", 64'(rsp_valid), 64'(0));
            chk("busy_wait", 64'(busy), 64'(1));
            chk("dp_a_hold", 64'(dp_a), 64'(ea));
        end
        if (noise) req = '0;
        step();
        chk("rspv", 64'(rsp_valid), 64'(oh));
        chk("rsp_y", 64'(rsp_y), 64'(ey));
        chk("busy_off", 64'(busy), 64'(0));
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;
        repeat (2) step();
        check_zero("rst");
        rst = 1'b0;
        step();

        // Single request 3+5
        a_in[0 +: W] = 16'd3;
        b_in[0 +: W] = 16'd5;
        do_op(4'b0001, 1'b0, 1'b0);

        // Carry discarded
        a_in[2*W +: W] = 16'hFFFF;
        b_in[2*W +: W] = 16'h0001;
        do_op(4'b0100, 1'b0, 1'b0);

        // Random requests, with churn on req/operands while busy
        for (int t = 0; t < 24; t++) begin
            rand_ops();
            do_op(N'($urandom_range(1, (1 << N) - 1)), 1'b0, 1'($urandom));
        end

        // No request: stays idle
        req = '0;
        for (int t = 0; t < 3; t++) begin
            step();
            chk("idle_gnt", 64'(gnt), 64'(0));
            chk("idle_busy", 64'(busy), 64'(0));
        end

        // Reset in WAIT abandons the op and clears the pointer
        rand_ops();
        req = 4'b0100;
        step();
        chk("pre_rst_gnt", 64'(gnt), 64'(4'b0100));
        req = '0;
        step();
        step();
        #2 rst = 1'b1;
        #1 check_zero("rst_wait");
        step();
        step();
        rst = 1'b0;
        for (int t = 0; t < LAT + 3; t++) begin
            step();
            chk("post_rst_rspv", 64'(rsp_valid), 64'(0));
            chk("post_rst_busy", 64'(busy), 64'(0));
        end
        ptr_m = 0;
        rand_ops();
        do_op(4'b1001, 1'b0, 1'b0);

`ifdef ADDER_SCHED_FIXED_PRIO_EN
        // Requester 1 always wins, 3 starves
        for (int t = 0; t < 4; t++) begin
            rand_ops();
            do_op(4'b1010, 1'b1, 1'b0);
        end
`endif

        // All requesting continuously
        for (int t = 0; t < 5; t++) begin
            rand_ops();
            do_op(4'b1111, 1'b1, 1'b0);
        end
        req = '0;
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
